seg_scan_scheduler: RTL

//  Time-multiplexes the four 8-bit stopwatch segment buses onto one shared

---
 rtl/watch_pkg.sv | 23 ++
 rtl/seg_scan_scheduler_if.sv | 24 ++
 rtl/scan_slot_timer.sv | 39 +++
 rtl/seg_scan_scheduler.sv | 111 +++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared stopwatch display types: digit index, scan-state encoding, bus widths
// and the anode one-hot helper used by the segment scan scheduler.
package watch_pkg;

    localparam int DISP = 8;
    localparam int NUM_DIG = 4;
    localparam logic [DISP-1:0] BLANK_SEG_DEF = 8'hFF;

    typedef logic [1:0] dig_idx_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Active-low anode pattern with only the selected digit driven low.
    function automatic logic [NUM_DIG-1:0] anode_for(input dig_idx_t dig);
        logic [NUM_DIG-1:0] one_hot;
        one_hot = {{(NUM_DIG-1){1'b0}}, 1'b1} << dig;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/seg_scan_scheduler_if.sv
// Display-side bundle of the segment scan scheduler: four per-digit segment
// inputs and enable in, shared segment bus, anodes and frame strobe out.
interface seg_scan_scheduler_if #(
    parameter int DISP = watch_pkg::DISP
);
    logic                           enable;
    logic [DISP-1:0]                seg_in0;
    logic [DISP-1:0]                seg_in1;
    logic [DISP-1:0]                seg_in2;
    logic [DISP-1:0]                seg_in3;
    logic [DISP-1:0]                seg_out;
    logic [watch_pkg::NUM_DIG-1:0]  an_out;
    logic                           frame_done;

    modport master (
        output enable, seg_in0, seg_in1, seg_in2, seg_in3,
        input  seg_out, an_out, frame_done
    );

    modport slave (
        input  enable, seg_in0, seg_in1, seg_in2, seg_in3,
        output seg_out, an_out, frame_done
    );
endinterface

// File: rtl/scan_slot_timer.sv
// Slot timer for the display scan: counts clk cycles within a digit slot,
// advances the digit index on each slot wrap and flags the end of a frame.
module scan_slot_timer
    import watch_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int CW       = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic [CW-1:0] cnt,
    output dig_idx_t      dig,
    output logic          frame_end
);

    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic slot_wrap_s;

    assign slot_wrap_s = (cnt == CNT_MAX);

    // Slot counter and digit index; frame_end is high for the cycle after digit 3 wraps.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt       <= CW'(0);
            dig       <= 2'd0;
            frame_end <= 1'b0;
        end else if (slot_wrap_s) begin
            cnt       <= CW'(0);
            dig       <= dig + 2'd1;
            frame_end <= (dig == 2'd3);
        end else begin
            cnt       <= cnt + CW'(1);
            frame_end <= 1'b0;
        end
    end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Multiplexes four 7-segment digit patterns onto one shared segment bus with a
// blanking gap per slot. Optional LEAD_ZERO_BLANK_EN darkens a leading-zero minutes-tens digit.
module seg_scan_scheduler #(
    parameter int               DISP      = 8,
    parameter int               SCAN_DIV  = 100000,
    parameter int               BLANK_CYC = 1000,
    parameter logic [DISP-1:0]  BLANK_SEG = watch_pkg::BLANK_SEG_DEF,
    parameter logic [DISP-1:0]  ZERO_SEG  = 8'hC0
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_scan_scheduler_if.slave   bus
);
    import watch_pkg::*;

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYC);
    localparam logic [NUM_DIG-1:0] AN_OFF = {NUM_DIG{1'b1}};
`ifdef LEAD_ZERO_BLANK_EN
    localparam logic LZB_EN = 1'b1;
`else
    localparam logic LZB_EN = 1'b0;
`endif

    if (BLANK_CYC < 1 || BLANK_CYC >= SCAN_DIV || SCAN_DIV < 2) begin : g_bad_param
        $error("seg_scan_scheduler: need SCAN_DIV >= 2 and 1 <= BLANK_CYC < SCAN_DIV");
    end

    logic [CW-1:0]     cnt_s;
    dig_idx_t          dig_s;
    logic              frame_end_s;
    logic [DISP-1:0]   sel_s;
    logic [DISP-1:0]   show_val_s;
    scan_state_t       state_r;
    logic [DISP-1:0]   cap_r;
    logic [DISP-1:0]   seg_r;
    logic [NUM_DIG-1:0] an_r;
    logic              frame_r;

    scan_slot_timer #(
        .SCAN_DIV (SCAN_DIV),
        .CW       (CW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .enable    (bus.enable),
        .cnt       (cnt_s),
        .dig       (dig_s),
        .frame_end (frame_end_s)
    );

    // A leading zero on the minutes-tens digit may be suppressed.
    function automatic logic lead_dark(input dig_idx_t dig, input logic [DISP-1:0] val);
        return LZB_EN && (dig == 2'd3) && (val == ZERO_SEG);
    endfunction

    // Pattern of the digit owning the current slot.
    always_comb begin
        sel_s = BLANK_SEG;
        case (dig_s)
            2'd0:    sel_s = bus.seg_in0;
            2'd1:    sel_s = bus.seg_in1;
            2'd2:    sel_s = bus.seg_in2;
            2'd3:    sel_s = bus.seg_in3;
            default: sel_s = BLANK_SEG;
        endcase
    end

    // Entering SHOW takes the live input; staying in SHOW replays the capture.
    always_comb begin
        show_val_s = cap_r;
        if (state_r == ST_BLANK) begin
            show_val_s = sel_s;
        end else begin
            show_val_s = cap_r;
        end
    end

    // Slot FSM with capture register and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst || !bus.enable) begin
            state_r <= ST_BLANK;
            cap_r   <= BLANK_SEG;
            seg_r   <= BLANK_SEG;
            an_r    <= AN_OFF;
            frame_r <= 1'b0;
        end else begin
            frame_r <= frame_end_s;
            if (cnt_s >= BLANK_C) begin
                state_r <= ST_SHOW;
                cap_r   <= show_val_s;
                if (lead_dark(dig_s, show_val_s)) begin
                    seg_r <= BLANK_SEG;
                    an_r  <= AN_OFF;
                end else begin
                    seg_r <= show_val_s;
                    an_r  <= anode_for(dig_s);
                end
            end else begin
                state_r <= ST_BLANK;
                seg_r   <= BLANK_SEG;
                an_r    <= AN_OFF;
            end
        end
    end

    assign bus.seg_out    = seg_r;
    assign bus.an_out     = an_r;
    assign bus.frame_done = frame_r;

endmodule
